coretest_core_mux: RTL and testbench

Parametrised, registered address decoder/mux between the coretest command master and up to NUM_CORES test-target cores on the 32-bit memory-like core bus. Each core owns one 256-word page selected by address bits [15:8]. The block adds three things to the plain combinational mux:
- a registered request/response pipeline with an explicit response strobe;
- error reporting for unmapped pages;
- an internal status page holding access counters and the last faulting address.

---
 rtl/coretest_core_mux.sv | 244 ++++++++++++++++++++++++
 tb/tb_coretest_core_mux.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coretest_core_mux.sv
// coretest_core_mux: registered address decoder/mux from the coretest command
// master onto up to NUM_CORES cores, with unmapped-page error reporting and an
// internal status page (access counters, last faulting address).
module coretest_core_mux #(
    parameter int unsigned NUM_CORES     = 4,
    parameter logic [7:0]  PREFIX_BASE   = 8'h00,
    parameter logic [7:0]  PREFIX_STRIDE = 8'h10,
    parameter logic [7:0]  STATUS_PREFIX = 8'hff
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      m_cs,
    input  logic                      m_we,
    input  logic [15:0]               m_address,
    input  logic [31:0]               m_write_data,
    output logic [31:0]               m_read_data,
    output logic                      m_error,
    output logic                      m_ready,
    output logic [NUM_CORES-1:0]      core_cs,
    output logic                      core_we,
    output logic [7:0]                core_address,
    output logic [31:0]               core_write_data,
    input  logic [32*NUM_CORES-1:0]   core_read_data,
    input  logic [NUM_CORES-1:0]      core_error
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;
    localparam int unsigned RW = 8;
    localparam int unsigned CW = 16;
    localparam logic [DW-1:0] CORE_ID = 32'h6d757820;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TGT_CORE     = 2'd0,
        TGT_STATUS   = 2'd1,
        TGT_UNMAPPED = 2'd2
    } tgt_t;

    state_t               state_q, state_d;
    tgt_t                 tgt_q, tgt_d;
    logic                 lat_we_q, lat_we_d;
    logic [AW-1:0]        lat_addr_q, lat_addr_d;
    logic [DW-1:0]        rd_q, rd_d;
    logic                 err_q, err_d;
    logic                 ready_q, ready_d;
    logic [NUM_CORES-1:0] cs_q, cs_d;
    logic                 we_q, we_d;
    logic [RW-1:0]        caddr_q, caddr_d;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic [CW-1:0]        unmapped_q, unmapped_d;
    logic [CW-1:0]        overrun_q, overrun_d;
    logic [AW-1:0]        last_err_q, last_err_d;

    logic [NUM_CORES-1:0] dec_cs;
    logic                 dec_status;
    logic [DW-1:0]        core_rd;
    logic                 core_err;
    logic [DW-1:0]        stat_rd;
    logic                 stat_err;
    logic                 stat_clr;

    // Page decode of the incoming master address.
    always_comb begin
        dec_cs = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (m_address[15:8] == PREFIX_BASE + 8'(i) * PREFIX_STRIDE) begin
                dec_cs[i] = 1'b1;
            end
        end
        dec_status = (m_address[15:8] == STATUS_PREFIX);
    end

    // Read-data/error mux of the core selected during ACCESS.
    always_comb begin
        core_rd  = '0;
        core_err = 1'b0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (cs_q[i]) begin
                core_rd  = core_rd | core_read_data[32*i +: 32];
                core_err = core_err | core_error[i];
            end
        end
    end

    // Status page register file: read value, error and counter-clear request.
    always_comb begin
        stat_rd  = '0;
        stat_err = 1'b0;
        stat_clr = 1'b0;
        case (lat_addr_q[7:0])
            8'h00: begin
                stat_rd  = CORE_ID;
                stat_err = lat_we_q;
            end
            8'h01: begin
                stat_rd  = DW'(NUM_CORES);
                stat_err = lat_we_q;
            end
            8'h02: begin
                stat_rd  = {16'h0, unmapped_q};
                stat_clr = lat_we_q;
            end
            8'h03: begin
                stat_rd  = {16'h0, overrun_q};
                stat_err = lat_we_q;
            end
            8'h04: begin
                stat_rd  = {16'h0, last_err_q};
                stat_err = lat_we_q;
            end
            default: begin
                stat_rd  = '0;
                stat_err = 1'b1;
            end
        endcase
    end

    // Next-state and next-register logic; core-side outputs default to 0.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        lat_we_d   = lat_we_q;
        lat_addr_d = lat_addr_q;
        rd_d       = rd_q;
        err_d      = err_q;
        ready_d    = 1'b0;
        cs_d       = '0;
        we_d       = 1'b0;
        caddr_d    = '0;
        wdata_d    = '0;
        unmapped_d = unmapped_q;
        overrun_d  = overrun_q;
        last_err_d = last_err_q;

        // Requests arriving while busy are dropped and counted.
        if (m_cs && (state_q != ST_IDLE) && (overrun_q != 16'hffff)) begin
            overrun_d = overrun_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (m_cs) begin
                    lat_we_d   = m_we;
                    lat_addr_d = m_address;
                    state_d    = ST_ACCESS;
                    if (|dec_cs) begin
                        tgt_d   = TGT_CORE;
                        cs_d    = dec_cs;
                        we_d    = m_we;
                        caddr_d = m_address[7:0];
                        wdata_d = m_write_data;
                    end else if (dec_status) begin
                        tgt_d = TGT_STATUS;
                    end else begin
                        tgt_d = TGT_UNMAPPED;
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESPOND;
                ready_d = 1'b1;
                case (tgt_q)
                    TGT_CORE: begin
                        rd_d  = core_rd;
                        err_d = core_err;
                    end
                    TGT_STATUS: begin
                        rd_d  = stat_rd;
                        err_d = stat_err;
                        // Clear overrides any increment in the same cycle.
                        if (stat_clr) begin
                            unmapped_d = '0;
                            overrun_d  = '0;
                        end
                    end
                    default: begin
                        rd_d       = '0;
                        err_d      = 1'b1;
                        last_err_d = lat_addr_q;
                        if (unmapped_q != 16'hffff) begin
                            unmapped_d = unmapped_q + 16'd1;
                        end
                    end
                endcase
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            tgt_q      <= TGT_CORE;
            lat_we_q   <= 1'b0;
            lat_addr_q <= '0;
            rd_q       <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            cs_q       <= '0;
            we_q       <= 1'b0;
            caddr_q    <= '0;
            wdata_q    <= '0;
            unmapped_q <= '0;
            overrun_q  <= '0;
            last_err_q <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            lat_we_q   <= lat_we_d;
            lat_addr_q <= lat_addr_d;
            rd_q       <= rd_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            caddr_q    <= caddr_d;
            wdata_q    <= wdata_d;
            unmapped_q <= unmapped_d;
            overrun_q  <= overrun_d;
            last_err_q <= last_err_d;
        end
    end

    assign m_read_data     = rd_q;
    assign m_error         = err_q;
    assign m_ready         = ready_q;
    assign core_cs         = cs_q;
    assign core_we         = we_q;
    assign core_address    = caddr_q;
    assign core_write_data = wdata_q;

endmodule

// File: tb/tb_coretest_core_mux.sv
// Testbench for coretest_core_mux: directed vector table, hand-written corner
// sequences and randomized transactions against a behavioural model.
module tb_coretest_core_mux;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         m_cs;
    logic         m_we;
    logic [15:0]  m_address;
    logic [31:0]  m_write_data;
    logic [31:0]  m_read_data;
    logic         m_error;
    logic         m_ready;
    logic [3:0]   core_cs;
    logic         core_we;
    logic [7:0]   core_address;
    logic [31:0]  core_write_data;
    logic [127:0] core_read_data;
    logic [3:0]   core_error;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int unsigned ref_unm;
    int unsigned ref_ovr;
    logic [15:0] ref_last;

    coretest_core_mux dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .m_cs            (m_cs),
        .m_we            (m_we),
        .m_address       (m_address),
        .m_write_data    (m_write_data),
        .m_read_data     (m_read_data),
        .m_error         (m_error),
        .m_ready         (m_ready),
        .core_cs         (core_cs),
        .core_we         (core_we),
        .core_address    (core_address),
        .core_write_data (core_write_data),
        .core_read_data  (core_read_data),
        .core_error      (core_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int core_idx(input logic [7:0] page);
        for (int i = 0; i < 4; i++) begin
            if (int'(page) == i * 16) return i;
        end
        return -1;
    endfunction

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v >= 32'hffff) ? 32'hffff : v + 1;
    endfunction

    // One master transaction; m_cs is held for 'hold' cycles (1..3).
    task automatic do_txn(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                          input int hold, output logic [31:0] a_rd, output logic a_err,
                          output logic [3:0] a_cs);
        int ci;
        logic [31:0] e_rd;
        logic e_err;
        logic [3:0] e_cs;
        bit chk_rd, is_unm, is_clr;
        ci = core_idx(addr[15:8]);
        e_cs = 4'b0; e_rd = 32'h0; e_err = 1'b1;
        chk_rd = 1; is_unm = 0; is_clr = 0;
        if (ci >= 0) begin
            e_cs  = 4'(1 << ci);
            e_rd  = core_read_data[32*ci +: 32];
            e_err = core_error[ci];
        end else if (addr[15:8] == 8'hff) begin
            chk_rd = !we;
            case (addr[7:0])
                8'h00: begin e_rd = 32'h6d757820; e_err = we; end
                8'h01: begin e_rd = 32'd4; e_err = we; end
                8'h02: begin e_rd = {16'h0, ref_unm[15:0]}; e_err = 1'b0; is_clr = we; end
                8'h03: begin e_rd = {16'h0, ref_ovr[15:0]}; e_err = we; end
                8'h04: begin e_rd = {16'h0, ref_last}; e_err = we; end
                default: begin e_rd = 32'h0; e_err = 1'b1; end
            endcase
        end else begin
            is_unm = 1;
        end

        @(negedge clk);
        m_cs = 1'b1; m_we = we; m_address = addr; m_write_data = wd;
        @(negedge clk);
        a_cs = core_cs;
        chk("core_cs", 32'(core_cs), 32'(e_cs));
        chk("core_we", 32'(core_we), (ci >= 0) ? 32'(we) : 32'h0);
        chk("core_address", 32'(core_address), (ci >= 0) ? 32'(addr[7:0]) : 32'h0);
        chk("core_write_data", core_write_data, (ci >= 0) ? wd : 32'h0);
        chk("ready_early", 32'(m_ready), 32'h0);
        m_cs = (hold >= 2);
        m_we = 1'($urandom); m_address = 16'($urandom); m_write_data = $urandom;
        @(negedge clk);
        chk("m_ready", 32'(m_ready), 32'h1);
        chk("m_error", 32'(m_error), 32'(e_err));
        if (chk_rd) chk("m_read_data", m_read_data, e_rd);
        chk("core_cs_respond", 32'(core_cs), 32'h0);
        a_rd = m_read_data; a_err = m_error;
        m_cs = (hold >= 3);
        @(negedge clk);
        chk("ready_pulse", 32'(m_ready), 32'h0);
        chk("core_cs_idle", 32'(core_cs), 32'h0);
        m_cs = 1'b0;

        if (is_unm) begin
            ref_unm  = sat_inc(ref_unm);
            ref_last = addr;
        end
        if (is_clr) begin
            ref_unm = 0;
            ref_ovr = (hold >= 3) ? 1 : 0;
        end else begin
            if (hold >= 2) ref_ovr = sat_inc(ref_ovr);
            if (hold >= 3) ref_ovr = sat_inc(ref_ovr);
        end
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wd;
        logic [3:0]  cs;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [31:0] rd;
        logic err;
        logic [3:0] cs;

        tbl[0]  = '{1'b0, 16'h2004, 32'h0,        4'b0100, 32'hdeadbeef, 1'b0};
        tbl[1]  = '{1'b1, 16'h0010, 32'h12345678, 4'b0001, 32'h0,        1'b0};
        tbl[2]  = '{1'b0, 16'h3011, 32'h0,        4'b1000, 32'hc3c30003, 1'b1};
        tbl[3]  = '{1'b0, 16'h5533, 32'h0,        4'b0000, 32'h0,        1'b1};
        tbl[4]  = '{1'b0, 16'hff02, 32'h0,        4'b0000, 32'h1,        1'b0};
        tbl[5]  = '{1'b0, 16'hff04, 32'h0,        4'b0000, 32'h5533,     1'b0};
        tbl[6]  = '{1'b0, 16'hff00, 32'h0,        4'b0000, 32'h6d757820, 1'b0};
        tbl[7]  = '{1'b0, 16'hff01, 32'h0,        4'b0000, 32'd4,        1'b0};
        tbl[8]  = '{1'b1, 16'hff00, 32'h55,       4'b0000, 32'h0,        1'b1};
        tbl[9]  = '{1'b0, 16'hff07, 32'h0,        4'b0000, 32'h0,        1'b1};
        tbl[10] = '{1'b0, 16'hff02, 32'h0,        4'b0000, 32'h1,        1'b0};
        tbl[11] = '{1'b1, 16'hff02, 32'h0,        4'b0000, 32'h0,        1'b0};
        tbl[12] = '{1'b0, 16'hff02, 32'h0,        4'b0000, 32'h0,        1'b0};

        ref_unm = 0; ref_ovr = 0; ref_last = 16'h0;
        m_cs = 1'b0; m_we = 1'b0; m_address = 16'h0; m_write_data = 32'h0;
        core_read_data = {32'hc3c30003, 32'hdeadbeef, 32'hc1c10001, 32'hc0c00000};
        core_error = 4'b1000;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_m_ready", 32'(m_ready), 32'h0);
        chk("rst_m_error", 32'(m_error), 32'h0);
        chk("rst_m_read_data", m_read_data, 32'h0);
        chk("rst_core_cs", 32'(core_cs), 32'h0);
        chk("rst_core_we", 32'(core_we), 32'h0);
        chk("rst_core_address", 32'(core_address), 32'h0);
        chk("rst_core_write_data", core_write_data, 32'h0);
        reset_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            do_txn(tbl[i].we, tbl[i].addr, tbl[i].wd, 1, rd, err, cs);
            chk("tbl_cs", 32'(cs), 32'(tbl[i].cs));
            chk("tbl_err", 32'(err), 32'(tbl[i].err));
            if (!tbl[i].we) chk("tbl_rd", rd, tbl[i].rd);
        end

        // m_cs held three cycles: one transaction, two overruns
        do_txn(1'b0, 16'h1000, 32'h0, 3, rd, err, cs);
        chk("ovr_single_txn_rd", rd, 32'hc1c10001);
        do_txn(1'b0, 16'hff03, 32'h0, 1, rd, err, cs);
        chk("ovr_cnt", rd, 32'h2);
        do_txn(1'b1, 16'hff02, 32'h0, 1, rd, err, cs);
        do_txn(1'b0, 16'hff03, 32'h0, 1, rd, err, cs);
        chk("ovr_cleared", rd, 32'h0);

        // Reset during ACCESS aborts the transaction
        @(negedge clk);
        m_cs = 1'b1; m_we = 1'b0; m_address = 16'h2004;
        @(negedge clk);
        m_cs = 1'b0;
        chk("abort_cs_before", 32'(core_cs), 32'h4);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_cs_drop", 32'(core_cs), 32'h0);
        chk("abort_addr_drop", 32'(core_address), 32'h0);
        chk("abort_ready", 32'(m_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_ready", 32'(m_ready), 32'h0);
        end
        reset_n = 1'b1;
        ref_unm = 0; ref_ovr = 0; ref_last = 16'h0;
        do_txn(1'b0, 16'h1000, 32'h0, 1, rd, err, cs);
        chk("post_reset_rd", rd, 32'hc1c10001);

        // Randomized transactions against the model
        for (int n = 0; n < 200; n++) begin
            int r;
            int h;
            logic [15:0] a;
            logic w;
            core_read_data = {$urandom, $urandom, $urandom, $urandom};
            core_error = 4'($urandom);
            r = int'($urandom_range(0, 9));
            if (r < 5)      a = {8'(16 * $urandom_range(0, 3)), 8'($urandom)};
            else if (r < 8) a = {8'hff, 8'($urandom_range(0, 6))};
            else            a = 16'($urandom);
            w = 1'($urandom);
            r = int'($urandom_range(0, 5));
            h = (r < 3) ? 1 : ((r < 5) ? 2 : 3);
            do_txn(w, a, $urandom, h, rd, err, cs);
        end
        do_txn(1'b0, 16'hff02, 32'h0, 1, rd, err, cs);
        do_txn(1'b0, 16'hff03, 32'h0, 1, rd, err, cs);
        do_txn(1'b0, 16'hff04, 32'h0, 1, rd, err, cs);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
